// File: rtl/modulation_interp.sv
// Amplitude modulator: a waveform buffer stepped on a power-of-two sample
// period, optional linear interpolation between adjacent samples, and a
// sequential per-channel duty scaler that commits all channels on one edge.
//
// Handshake: START is a request that is accepted only when BUSY is low
// (state IDLE). Nothing is queued. OUT_VALID is a one-cycle pulse that marks
// the cycle in which a new DUTY_M set first appears. DUTY_M holds its value
// until the next OUT_VALID.
module modulation_interp #(
  parameter int WIDTH      = 13,
  parameter int DEPTH      = 249,
  parameter int MOD_WIDTH  = 8,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     BUF_WE,
  input  logic [ADDR_WIDTH-1:0]    BUF_ADDR,
  input  logic [MOD_WIDTH-1:0]     BUF_DIN,
  input  logic [ADDR_WIDTH-1:0]    MOD_CYCLE,
  input  logic [4:0]               DIV_LOG2,
  input  logic                     INTERP_EN,
  input  logic                     SYNC,
  input  logic                     START,
  input  logic [WIDTH*DEPTH-1:0]   DUTY,
  output logic [WIDTH*DEPTH-1:0]   DUTY_M,
  output logic                     OUT_VALID,
  output logic                     BUSY,
  output logic [ADDR_WIDTH-1:0]    MOD_IDX,
  output logic [2:0]               DBG_STATE
);

  localparam int CH_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW   = MOD_WIDTH + 17;
  localparam int SW   = WIDTH + MOD_WIDTH + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(DEPTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD0    = 3'd1;
  localparam logic [2:0] S_RD1    = 3'd2;
  localparam logic [2:0] S_INTERP = 3'd3;
  localparam logic [2:0] S_SCALE  = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;

  logic [2:0]             state;
  logic [15:0]            div_cnt;
  logic [15:0]            div_mask;
  logic [ADDR_WIDTH-1:0]  mod_len;
  logic [ADDR_WIDTH:0]    idx_inc;
  logic [ADDR_WIDTH-1:0]  idx_next;

  logic [MOD_WIDTH-1:0]   mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [MOD_WIDTH-1:0]   rd_data;

  logic [ADDR_WIDTH-1:0]  i0, i1;
  logic [15:0]            frac;
  logic [4:0]             shift;
  logic [MOD_WIDTH-1:0]   s0, m;
  logic [CH_W-1:0]        ch;
  logic [WIDTH*DEPTH-1:0] shadow;

  logic signed [MOD_WIDTH:0] diff;
  logic signed [PW-1:0]      diff_x, frac_x, prod, step;
  logic [MOD_WIDTH-1:0]      m_calc;
  logic [WIDTH-1:0]          duty_k;
  logic [MOD_WIDTH:0]        m_plus1;
  logic [SW-1:0]             scale_prod;
  logic [WIDTH-1:0]          scaled;
  logic                      unused_bits;

  // Sample-period mask and wrap-aware next index (0 length behaves as 1).
  always_comb begin
    div_mask = (DIV_LOG2 >= 5'd16) ? 16'hFFFF : ((16'd1 << DIV_LOG2) - 16'd1);
    mod_len  = (MOD_CYCLE == '0) ? ADDR_WIDTH'(1) : MOD_CYCLE;
    idx_inc  = {1'b0, MOD_IDX} + 1'b1;
    idx_next = (idx_inc >= {1'b0, mod_len}) ? '0 : idx_inc[ADDR_WIDTH-1:0];
  end

  // Timebase: SYNC restarts, a shrunken length snaps the index to 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt <= '0;
      MOD_IDX <= '0;
    end else if (SYNC) begin
      div_cnt <= '0;
      MOD_IDX <= '0;
    end else begin
      div_cnt <= (div_cnt == div_mask) ? 16'd0 : div_cnt + 16'd1;
      if (MOD_IDX >= mod_len)
        MOD_IDX <= '0;
      else if (div_cnt == div_mask)
        MOD_IDX <= idx_next;
    end
  end

  // Waveform buffer: write port from the bus, registered read-first port.
  always_ff @(posedge CLK) begin
    if (BUF_WE)
      mem[BUF_ADDR] <= BUF_DIN;
    rd_data <= mem[rd_addr];
  end

  // Read address and interpolation/scaling datapath.
  always_comb begin
    rd_addr    = (state == S_RD1) ? i1 : i0;
    diff       = $signed({1'b0, rd_data}) - $signed({1'b0, s0});
    diff_x     = {{(PW-MOD_WIDTH-1){diff[MOD_WIDTH]}}, diff};
    frac_x     = {{(PW-16){1'b0}}, frac};
    prod       = diff_x * frac_x;
    step       = prod >>> shift;
    // The floored step keeps the result between s0 and s1, so the low bits suffice.
    m_calc     = (!INTERP_EN || shift == 5'd0) ? s0 : s0 + step[MOD_WIDTH-1:0];
    duty_k     = DUTY[int'(ch)*WIDTH +: WIDTH];
    m_plus1    = {1'b0, m} + 1'b1;
    scale_prod = {{(MOD_WIDTH+1){1'b0}}, duty_k} * {{WIDTH{1'b0}}, m_plus1};
    scaled     = (m == '0) ? '0 : scale_prod[MOD_WIDTH +: WIDTH];
    unused_bits = ^{step[PW-1:MOD_WIDTH], scale_prod[SW-1], scale_prod[MOD_WIDTH-1:0]};
  end

  // Control FSM: latch the sample point, read two samples, interpolate,
  // scale one channel per cycle into the shadow, then commit atomically.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      OUT_VALID <= 1'b0;
      DUTY_M    <= '0;
      ch        <= '0;
    end else begin
      OUT_VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            i0    <= MOD_IDX;
            i1    <= idx_next;
            frac  <= div_cnt & div_mask;
            shift <= DIV_LOG2;
            state <= S_RD0;
          end
        end
        S_RD0: state <= S_RD1;
        S_RD1: begin
          s0    <= rd_data;
          state <= S_INTERP;
        end
        S_INTERP: begin
          m     <= m_calc;
          ch    <= '0;
          state <= S_SCALE;
        end
        S_SCALE: begin
          shadow[int'(ch)*WIDTH +: WIDTH] <= scaled;
          if (ch == LAST_CH)
            state <= S_COMMIT;
          else
            ch <= ch + 1'b1;
        end
        S_COMMIT: begin
          DUTY_M    <= shadow;
          OUT_VALID <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY      = (state != S_IDLE);
  assign DBG_STATE = state;

endmodule

// File: tb/tb_modulation_interp.sv
// Directed bench for modulation_interp: driver tasks issue SYNC/START
// sequences and push the expected commit (cycle, duty) into a queue; a
// negedge monitor pops and compares whenever OUT_VALID is seen.
module tb_modulation_interp;

  localparam int WIDTH      = 13;
  localparam int DEPTH      = 249;
  localparam int MOD_WIDTH  = 8;
  localparam int ADDR_WIDTH = 15;
  localparam int W          = 32 + WIDTH;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   buf_we;
  logic [ADDR_WIDTH-1:0]  buf_addr;
  logic [MOD_WIDTH-1:0]   buf_din;
  logic [ADDR_WIDTH-1:0]  mod_cycle;
  logic [4:0]             div_log2;
  logic                   interp_en;
  logic                   sync;
  logic                   start;
  logic [WIDTH*DEPTH-1:0] duty;
  logic [WIDTH*DEPTH-1:0] duty_m;
  logic                   out_valid;
  logic                   busy;
  logic [ADDR_WIDTH-1:0]  mod_idx;
  logic [2:0]             dbg_state;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic prev_ov = 1'b0;

  modulation_interp #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .MOD_WIDTH(MOD_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .CLK(clk), .RST(rst), .BUF_WE(buf_we), .BUF_ADDR(buf_addr), .BUF_DIN(buf_din),
    .MOD_CYCLE(mod_cycle), .DIV_LOG2(div_log2), .INTERP_EN(interp_en),
    .SYNC(sync), .START(start), .DUTY(duty), .DUTY_M(duty_m),
    .OUT_VALID(out_valid), .BUSY(busy), .MOD_IDX(mod_idx), .DBG_STATE(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic write_buf(input int a, input int d);
    buf_addr = ADDR_WIDTH'(a);
    buf_din  = MOD_WIDTH'(d);
    buf_we   = 1'b1;
    tick();
    buf_we   = 1'b0;
  endtask

  // After this returns the timebase sits at index 0, count 0.
  task automatic do_sync();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  task automatic issue_start(input bit expect_out, input int dm);
    if (expect_out)
      exp_q.push_back({32'(cyc + DEPTH + 5), WIDTH'(dm)});
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_first", busy, 1);
  endtask

  // elapsed = cycles spent since the cycle after START
  task automatic wait_done(input int elapsed);
    ticks(DEPTH + 3 - elapsed);
    check("busy_last", busy, 1);
    tick();
    check("busy_clear", busy, 0);
    ticks(2);
  endtask

  task automatic run_at(input int n, input int dm);
    do_sync();
    ticks(n);
    issue_start(1'b1, dm);
    wait_done(0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (out_valid) begin
      check("out_valid_width", prev_ov, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        logic [W-1:0] e;
        int bad;
        int first_bad;
        e = exp_q.pop_front();
        check("out_valid_cycle", cyc, e[W-1:WIDTH]);
        bad = 0;
        first_bad = 0;
        for (int k = 0; k < DEPTH; k++) begin
          if (duty_m[k*WIDTH +: WIDTH] !== e[WIDTH-1:0]) begin
            if (bad == 0) first_bad = k;
            bad++;
          end
        end
        check("duty_m_value", duty_m[first_bad*WIDTH +: WIDTH], e[WIDTH-1:0]);
        if (bad != 0)
          $display("  channels differing: %0d, first %0d", bad, first_bad);
      end
    end
    prev_ov = out_valid;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst = 1'b1; buf_we = 1'b0; buf_addr = '0; buf_din = '0;
    mod_cycle = 15'd4; div_log2 = 5'd2; interp_en = 1'b0;
    sync = 1'b0; start = 1'b0;
    for (int k = 0; k < DEPTH; k++) duty[k*WIDTH +: WIDTH] = 13'd2500;
    ticks(3);
    rst = 1'b0;
    check("rst_duty_m_zero", (duty_m == '0), 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mod_idx", mod_idx, 0);

    write_buf(0, 0);
    write_buf(1, 64);
    write_buf(2, 128);
    write_buf(3, 255);

    // Sample-and-hold at index 2 -> m = 128
    run_at(8, 1259);

    // Index 3 -> m = 255 passes DUTY; buffer write lands while busy
    do_sync();
    ticks(12);
    issue_start(1'b1, 2500);
    ticks(9);
    write_buf(3, 0);
    wait_done(10);

    // buf[3] = 0 -> m = 0 forces zero
    run_at(12, 0);
    write_buf(3, 255);

    // Interpolation: idx 0, frac 2 -> m = 32
    interp_en = 1'b1;
    run_at(2, 322);

    // Interpolation across the wrap: idx 3, frac 2 -> m = 127
    run_at(14, 1250);

    // MOD_IDX stepping 0,1,2,3,0 every 4 CLK
    do_sync();
    for (int n = 0; n < 20; n++) begin
      check("mod_idx_seq", mod_idx, (n / 4) % 4);
      tick();
    end

    // Second START while busy is ignored
    do_sync();
    ticks(8);
    issue_start(1'b1, 1259);
    ticks(9);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(10);

    // Length shrinks under the current index
    do_sync();
    ticks(12);
    check("mod_idx_before_shrink", mod_idx, 3);
    mod_cycle = 15'd2;
    tick();
    check("mod_idx_after_shrink", mod_idx, 0);
    mod_cycle = 15'd4;

    // Reset in SCALE channel 50 aborts without commit
    do_sync();
    ticks(14);
    issue_start(1'b0, 0);
    ticks(53);
    check("state_in_scale", dbg_state, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_duty_m_zero", (duty_m == '0), 1);
    check("abort_busy", busy, 0);
    check("abort_mod_idx", mod_idx, 0);
    ticks(DEPTH + 10);

    // Normal run after the abort
    run_at(14, 1250);

    ticks(5);
    check("exp_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
